ref_rmw_accum: RTL and testbench

- Small register bank updated by read-modify-write add requests: a requester hands over an index and an increment, and the block updates the stored value after a fixed programmable delay.
- Hardware counterpart of the "pass by ref, delay, then add" update pattern.
- Sits downstream of a request producer (task/driver) and upstream of a change monitor, which consumes the response and change-event outputs.
- Single-outstanding request engine with valid/ready on both request and response sides.

---
 rtl/ref_rmw_accum_if.sv | 34 +++
 rtl/ref_rmw_accum.sv | 110 +++++++++++
 tb/tb_ref_rmw_accum.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ref_rmw_accum_if.sv
// Request/response/change-event bundle for ref_rmw_accum.
// master = request producer and response consumer; slave = the accumulator.
interface ref_rmw_accum_if #(
    parameter int unsigned DW   = 4,
    parameter int unsigned NREG = 4
);
    localparam int unsigned AW = $clog2(NREG);

    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_idx;
    logic [DW-1:0] req_inc;
    logic          req_sat;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [AW-1:0] rsp_idx;
    logic [DW-1:0] rsp_old;
    logic [DW-1:0] rsp_new;
    logic          rsp_ovf;

    logic          chg_pulse;
    logic [AW-1:0] chg_idx;

    modport master (
        output req_valid, req_idx, req_inc, req_sat, rsp_ready,
        input  req_ready, rsp_valid, rsp_idx, rsp_old, rsp_new, rsp_ovf, chg_pulse, chg_idx
    );

    modport slave (
        input  req_valid, req_idx, req_inc, req_sat, rsp_ready,
        output req_ready, rsp_valid, rsp_idx, rsp_old, rsp_new, rsp_ovf, chg_pulse, chg_idx
    );
endinterface

// File: rtl/ref_rmw_accum.sv
// Register bank updated by delayed read-modify-write add requests, one outstanding at a time.
// Each request waits WAIT_CYC cycles, adds (wrap or saturate), then holds a response.
module ref_rmw_accum #(
    parameter int unsigned DW       = 4,
    parameter int unsigned NREG     = 4,
    parameter int unsigned WAIT_CYC = 2,
    localparam int unsigned AW      = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ref_rmw_accum_if.slave        bus,
    input  logic [AW-1:0]         i_rd_idx,
    output logic [DW-1:0]         o_rd_data
);
    localparam logic [3:0] CntLoad = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);

    typedef enum logic [1:0] {StIdle, StWait, StUpdate, StResp} state_e;

    state_e        r_state;
    logic [3:0]    r_cnt;
    logic [DW-1:0] r_mem [NREG];
    logic [AW-1:0] r_idx;
    logic [DW-1:0] r_inc;
    logic          r_sat;
    logic          r_rsp_valid;
    logic [AW-1:0] r_rsp_idx;
    logic [DW-1:0] r_rsp_old;
    logic [DW-1:0] r_rsp_new;
    logic          r_rsp_ovf;
    logic          r_chg_pulse;
    logic [AW-1:0] r_chg_idx;

    logic [DW-1:0] w_old;
    logic [DW:0]   w_sum;
    logic          w_ovf;
    logic [DW-1:0] w_new;

    assign w_old = r_mem[r_idx];
    assign w_sum = {1'b0, w_old} + {1'b0, r_inc};
    assign w_ovf = w_sum[DW];
    assign w_new = (r_sat && w_ovf) ? {DW{1'b1}} : w_sum[DW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= 4'd0;
            for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
            r_idx       <= '0;
            r_inc       <= '0;
            r_sat       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_idx   <= '0;
            r_rsp_old   <= '0;
            r_rsp_new   <= '0;
            r_rsp_ovf   <= 1'b0;
            r_chg_pulse <= 1'b0;
            r_chg_idx   <= '0;
        end else begin
            r_chg_pulse <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (bus.req_valid) begin
                        r_idx <= bus.req_idx;
                        r_inc <= bus.req_inc;
                        r_sat <= bus.req_sat;
                        if (WAIT_CYC > 0) begin
                            r_state <= StWait;
                            r_cnt   <= CntLoad;
                        end else begin
                            r_state <= StUpdate;
                        end
                    end
                end
                StWait: begin
                    if (r_cnt == 4'd0) r_state <= StUpdate;
                    else               r_cnt   <= r_cnt - 4'd1;
                end
                StUpdate: begin
                    r_mem[r_idx] <= w_new;
                    r_rsp_idx    <= r_idx;
                    r_rsp_old    <= w_old;
                    r_rsp_new    <= w_new;
                    r_rsp_ovf    <= w_ovf;
                    r_chg_pulse  <= (w_new != w_old);
                    r_chg_idx    <= r_idx;
                    r_rsp_valid  <= 1'b1;
                    r_state      <= StResp;
                end
                StResp: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Gated by rst_n so the producer never sees ready while reset is held.
    assign bus.req_ready = rst_n & (r_state == StIdle);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_idx   = r_rsp_idx;
    assign bus.rsp_old   = r_rsp_old;
    assign bus.rsp_new   = r_rsp_new;
    assign bus.rsp_ovf   = r_rsp_ovf;
    assign bus.chg_pulse = r_chg_pulse;
    assign bus.chg_idx   = r_chg_idx;
    assign o_rd_data     = r_mem[i_rd_idx];
endmodule

// File: tb/tb_ref_rmw_accum.sv
// Bench for ref_rmw_accum: transaction-level model checked every cycle, plus directed literals.
module tb_ref_rmw_accum;
    localparam int unsigned DW   = 4;
    localparam int unsigned NREG = 4;
    localparam int unsigned W    = 2;
    localparam int          MAXV = (1 << DW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    ref_rmw_accum_if #(.DW(DW), .NREG(NREG)) bus ();
    ref_rmw_accum_if #(.DW(DW), .NREG(NREG)) bus0 ();
    ref_rmw_accum_if #(.DW(DW), .NREG(NREG)) bus5 ();

    logic [1:0] rd_idx, rd_idx0, rd_idx5;
    logic [3:0] rd_data, rd_data0, rd_data5;

    ref_rmw_accum #(.DW(DW), .NREG(NREG), .WAIT_CYC(W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .i_rd_idx(rd_idx), .o_rd_data(rd_data)
    );
    ref_rmw_accum #(.DW(DW), .NREG(NREG), .WAIT_CYC(0)) dut_w0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .i_rd_idx(rd_idx0), .o_rd_data(rd_data0)
    );
    ref_rmw_accum #(.DW(DW), .NREG(NREG), .WAIT_CYC(5)) dut_w5 (
        .clk(clk), .rst_n(rst_n), .bus(bus5), .i_rd_idx(rd_idx5), .o_rd_data(rd_data5)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a request accepted while idle yields its result W+1 edges later.
    int m_mem [NREG];
    bit m_pend, m_rv;
    int m_cnt, m_idx, m_inc, m_sat;
    int m_ridx, m_old, m_new, m_ovf, m_chg, m_cidx;

    initial begin : model
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < NREG; i++) m_mem[i] = 0;
                m_pend = 1'b0; m_rv = 1'b0; m_chg = 0;
            end else begin
                m_chg = 0;
                if (m_rv) begin
                    if (bus.rsp_ready) m_rv = 1'b0;
                end else if (m_pend) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        int s;
                        s      = m_mem[m_idx] + m_inc;
                        m_old  = m_mem[m_idx];
                        m_ovf  = (s > MAXV) ? 1 : 0;
                        m_new  = (m_ovf == 1 && m_sat == 1) ? MAXV : s % (MAXV + 1);
                        m_mem[m_idx] = m_new;
                        m_ridx = m_idx;
                        m_chg  = (m_new != m_old) ? 1 : 0;
                        m_cidx = m_idx;
                        m_pend = 1'b0;
                        m_rv   = 1'b1;
                    end
                end else if (bus.req_valid) begin
                    m_pend = 1'b1;
                    m_cnt  = W + 1;
                    m_idx  = int'(bus.req_idx);
                    m_inc  = int'(bus.req_inc);
                    m_sat  = int'(bus.req_sat);
                end
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("req_ready", int'(bus.req_ready), int'(rst_n && !m_pend && !m_rv));
                chk("rsp_valid", int'(bus.rsp_valid), int'(m_rv));
                chk("chg_pulse", int'(bus.chg_pulse), m_chg);
                if (m_chg == 1) chk("chg_idx", int'(bus.chg_idx), m_cidx);
                if (m_rv) begin
                    chk("rsp_idx", int'(bus.rsp_idx), m_ridx);
                    chk("rsp_old", int'(bus.rsp_old), m_old);
                    chk("rsp_new", int'(bus.rsp_new), m_new);
                    chk("rsp_ovf", int'(bus.rsp_ovf), m_ovf);
                end
                chk("rd_data", int'(rd_data), m_mem[rd_idx]);
            end
        end
    end

    task automatic send(input int idx, input int inc, input int sat, output int acc_cyc);
        bit ok = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_idx   = 2'(idx);
        bus.req_inc   = 4'(inc);
        bus.req_sat   = 1'(sat);
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (bus.req_ready) ok = 1'b1;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int rsp_cyc);
        bit ok = 1'b0;
        rsp_cyc = -1;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (bus.rsp_valid) begin
                ok = 1'b1;
                rsp_cyc = cyc;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (!ok) chk("rsp_timeout", 0, 1);
    endtask

    task automatic consume();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
    endtask

    // One transaction with hand-computed old/new/ovf/chg; latency counts the accepting edge.
    task automatic txn(input int idx, input int inc, input int sat, input int e_old,
                       input int e_new, input int e_ovf, input int e_chg, input string tag);
        int acc, rc;
        rd_idx = 2'(idx);
        send(idx, inc, sat, acc);
        wait_rsp(rc);
        chk({tag, "_latency"}, rc - acc + 1, W + 2);
        chk({tag, "_old"}, int'(bus.rsp_old), e_old);
        chk({tag, "_new"}, int'(bus.rsp_new), e_new);
        chk({tag, "_ovf"}, int'(bus.rsp_ovf), e_ovf);
        chk({tag, "_chg"}, int'(bus.chg_pulse), e_chg);
        chk({tag, "_rd"}, int'(rd_data), e_new);
        consume();
    endtask

    initial begin : stim
        int acc, acc2, rc, t, n, l0, l5;
        bus.req_valid = 0; bus.req_idx = 0; bus.req_inc = 0; bus.req_sat = 0; bus.rsp_ready = 0;
        bus0.req_valid = 0; bus0.req_idx = 0; bus0.req_inc = 0; bus0.req_sat = 0;
        bus0.rsp_ready = 0;
        bus5.req_valid = 0; bus5.req_idx = 0; bus5.req_inc = 0; bus5.req_sat = 0;
        bus5.rsp_ready = 0;
        rd_idx = 0; rd_idx0 = 0; rd_idx5 = 0;

        #2 rst_n = 1'b0;
        #20;
        chk("rst_req_ready", int'(bus.req_ready), 0);
        chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
        chk("rst_rsp_new", int'(bus.rsp_new), 0);
        chk("rst_rsp_ovf", int'(bus.rsp_ovf), 0);
        chk("rst_chg_pulse", int'(bus.chg_pulse), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        chk_en = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", int'(bus.req_ready), 1);

        // WAIT_CYC=0 and WAIT_CYC=5 instances: idx=2 inc=7
        bus0.req_valid = 1; bus0.req_idx = 2; bus0.req_inc = 7;
        bus5.req_valid = 1; bus5.req_idx = 2; bus5.req_inc = 7;
        rd_idx0 = 2; rd_idx5 = 2;
        @(posedge clk);
        #1;
        bus0.req_valid = 0; bus5.req_valid = 0;
        n = 1; l0 = 0; l5 = 0;
        for (int i = 0; i < 12; i++) begin
            if (l0 == 0 && bus0.rsp_valid) l0 = n;
            if (l5 == 0 && bus5.rsp_valid) l5 = n;
            @(posedge clk);
            #1;
            n++;
        end
        chk("w0_latency", l0, 2);
        chk("w5_latency", l5, 7);
        chk("w0_new", int'(bus0.rsp_new), 7);
        chk("w5_new", int'(bus5.rsp_new), 7);
        chk("w0_rd", int'(rd_data0), 7);
        chk("w5_rd", int'(rd_data5), 7);
        bus0.rsp_ready = 1; bus5.rsp_ready = 1;

        txn(1, 5, 0, 0, 5, 0, 1, "first");

        // Back-to-back with response always taken
        rd_idx = 1;
        bus.rsp_ready = 1'b1;
        send(1, 3, 0, acc);
        send(1, 5, 0, acc2);
        chk("b2b_spacing", acc2 - acc, 5);
        wait_rsp(rc);
        chk("b2b_old", int'(bus.rsp_old), 8);
        chk("b2b_new", int'(bus.rsp_new), 13);
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        chk("b2b_rd", int'(rd_data), 13);

        txn(1, 5, 0, 13, 2, 1, 1, "wrap");
        txn(1, 11, 0, 2, 13, 0, 1, "refill");
        txn(1, 5, 1, 13, 15, 1, 1, "sat");
        txn(1, 4, 1, 15, 15, 1, 0, "sat_hold");
        txn(1, 0, 0, 15, 15, 0, 0, "zero_inc");

        // Backpressure with a competing request held valid
        rd_idx = 0;
        send(0, 6, 0, acc);
        wait_rsp(rc);
        bus.req_valid = 1; bus.req_idx = 0; bus.req_inc = 1; bus.req_sat = 0;
        for (int i = 0; i < 6; i++) begin
            chk("bp_new_stable", int'(bus.rsp_new), 6);
            chk("bp_ready_low", int'(bus.req_ready), 0);
            @(posedge clk);
            #1;
        end
        chk("bp_no_update", int'(rd_data), 6);
        t = cyc;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        send(0, 1, 0, acc);
        chk("bp_accept_cycle", acc - t, 2);
        wait_rsp(rc);
        chk("bp_next_new", int'(bus.rsp_new), 7);
        consume();

        // Reset during WAIT aborts the operation
        rd_idx = 3;
        send(3, 9, 0, acc);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_ready", int'(bus.req_ready), 0);
        chk("abort_rsp_valid", int'(bus.rsp_valid), 0);
        chk("abort_rsp_new", int'(bus.rsp_new), 0);
        chk("abort_rsp_old", int'(bus.rsp_old), 0);
        chk("abort_rsp_idx", int'(bus.rsp_idx), 0);
        chk("abort_chg_idx", int'(bus.chg_idx), 0);
        rd_idx = 1;
        #1;
        chk("abort_reg1_clr", int'(rd_data), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        rd_idx = 3;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            chk("abort_no_rsp", int'(bus.rsp_valid), 0);
        end
        chk("abort_ready_back", int'(bus.req_ready), 1);
        chk("abort_reg3", int'(rd_data), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end
endmodule
